// File: rtl/multi_clk_div_if.sv
// Register-port bundle for multi_clk_div: divisor write and divisor readback.
//   wr_en   divisor write strobe
//   wr_ch   channel index for the write
//   wr_div  new divisor value
//   rd_ch   channel index for readback
//   rd_div  registered divisor of channel rd_ch (1-cycle latency)
interface multi_clk_div_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned WIDTH = 16
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic [CH_W-1:0]  rd_ch;
    logic [WIDTH-1:0] rd_div;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_div,
        output rd_ch,
        input  rd_div
    );

    modport slave (
        input  wr_en,
        input  wr_ch,
        input  wr_div,
        input  rd_ch,
        output rd_div
    );
endinterface

// File: rtl/multi_clk_div.sv
// Runtime-programmable multi-channel clock divider.
// Each channel produces a one-cycle tick every D enabled cycles and a 50%
// square wave of period 2*D; D is writable and readable via reg_if.
//   clock      system clock, rising edge
//   reset      synchronous, active-low reset
//   en_i       per-channel count enable
//   sync_i     global phase-align strobe (clears all counters and clk_out)
//   reg_if     divisor write / readback port (slave side)
//   tick_o     one-cycle strobe per channel period
//   clk_out_o  square wave per channel
module multi_clk_div #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 25000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    multi_clk_div_if.slave    reg_if,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_out_o
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0]  div_q [NUM_CH];
    logic [WIDTH-1:0]  div_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [WIDTH-1:0]  rd_div_q, rd_div_d;
    logic [NUM_CH-1:0] wr_hit_c;

    // Decode the write port; out-of-range channel indices match nothing.
    always_comb begin
        wr_hit_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = reg_if.wr_en && (reg_if.wr_ch == CH_W'(i));
        end
    end

    // Per-channel next state: sync > write > hold > wrap > count.
    always_comb begin
        tick_d   = '0;
        clk_d    = clk_q;
        rd_div_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = cnt_q[i];
        end

        for (int i = 0; i < NUM_CH; i++) begin
            // Divisor update is independent of sync.
            if (wr_hit_c[i]) begin
                div_d[i] = reg_if.wr_div;
            end

            if (sync_i) begin
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
            end else if (wr_hit_c[i]) begin
                // Restart the period; clk_out keeps its level.
                cnt_d[i] = '0;
            end else if (en_i[i] && (div_q[i] != '0)) begin
                if (cnt_q[i] == div_q[i] - ONE) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    clk_d[i]  = ~clk_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end

            // Readback uses the pre-write divisor; rd_ch out of range reads 0.
            if (reg_if.rd_ch == CH_W'(i)) begin
                rd_div_d = div_q[i];
            end
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
            tick_q   <= '0;
            clk_q    <= '0;
            rd_div_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            tick_q   <= tick_d;
            clk_q    <= clk_d;
            rd_div_q <= rd_div_d;
        end
    end

    assign tick_o        = tick_q;
    assign clk_out_o     = clk_q;
    assign reg_if.rd_div = rd_div_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed bench for multi_clk_div with an arithmetic reference model.
module tb_multi_clk_div;

    localparam int NCH  = 4;
    localparam int CHW  = 3;
    localparam int W    = 16;
    localparam int DDEF = 25000;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;

    multi_clk_div_if #(.CH_W(CHW), .WIDTH(W)) bus ();

    multi_clk_div #(
        .NUM_CH(NCH), .CH_W(CHW), .WIDTH(W), .DEFAULT_DIV(DDEF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en_i     (en),
        .sync_i   (sync),
        .reg_if   (bus),
        .tick_o   (tick),
        .clk_out_o(clk_out)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n = enabled counting edges since the last restart;
    // tick when n is a nonzero multiple of D, level = start level ^ parity(n/D).
    int             n    [NCH];
    int             mdiv [NCH];
    logic [NCH-1:0] etick, eclk, lvl0;
    logic [W-1:0]   erd;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                mdiv[i] = DDEF; n[i] = 0;
            end
            etick = '0; eclk = '0; lvl0 = '0; erd = '0;
        end else begin
            erd = (int'(bus.rd_ch) < NCH) ? W'(mdiv[bus.rd_ch]) : '0;
            for (int i = 0; i < NCH; i++) begin
                etick[i] = 1'b0;
                if (sync) begin
                    n[i] = 0; lvl0[i] = 1'b0; eclk[i] = 1'b0;
                end else if (bus.wr_en && int'(bus.wr_ch) == i) begin
                    n[i] = 0; lvl0[i] = eclk[i];
                end else if (en[i] && mdiv[i] != 0) begin
                    n[i]++;
                    etick[i] = (n[i] % mdiv[i]) == 0;
                    eclk[i]  = lvl0[i] ^ ((n[i] / mdiv[i]) % 2 == 1);
                end
            end
            if (bus.wr_en && int'(bus.wr_ch) < NCH) mdiv[bus.wr_ch] = int'(bus.wr_div);
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clock) begin
        if (chk_on) begin
            chk("tick", 32'(tick), 32'(etick));
            chk("clk_out", 32'(clk_out), 32'(eclk));
            chk("rd_div", 32'(bus.rd_div), 32'(erd));
        end
    end

    task automatic wr(input int ch, input int d);
        bus.wr_en  = 1'b1;
        bus.wr_ch  = CHW'(ch);
        bus.wr_div = W'(d);
        @(negedge clock);
        bus.wr_en  = 1'b0;
    endtask

    int       first, gap, e0, e3;
    bit       found;
    logic [5:0] tp, cp;
    logic     held;
    int       bad_clk, any_tick;

    initial begin
        reset = 1'b0; en = '0; sync = 1'b0;
        bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_div = 16'd7; bus.rd_ch = '0;
        repeat (3) @(negedge clock);
        chk_on = 1'b1;
        chk("reset_tick", 32'(tick), 0);
        chk("reset_clk", 32'(clk_out), 0);
        chk("reset_rd", 32'(bus.rd_div), 0);

        // Defaults on channel 0.
        reset = 1'b1; bus.wr_en = 1'b0; en = 4'b0001;
        first = 0;
        for (int e = 1; e <= 25100 && first == 0; e++) begin
            @(negedge clock);
            if (tick[0]) first = e;
        end
        chk("first_tick_edge", 32'(first), 25000);
        chk("clk0_after_first", 32'(clk_out[0]), 1);
        gap = 0; found = 0;
        for (int e = 1; e <= 25100 && !found; e++) begin
            @(negedge clock);
            if (tick[0]) begin gap = e; found = 1; end
        end
        chk("tick0_gap", 32'(gap), 25000);
        chk("clk0_half_period_end", 32'(clk_out[0]), 0);

        // Channel 1 D=3.
        en = 4'b0011; bus.rd_ch = 3'd1;
        wr(1, 3);
        chk("rd_old_at_write", 32'(bus.rd_div), 25000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 0) chk("rd_new_after_write", 32'(bus.rd_div), 3);
            tp[k] = tick[1]; cp[k] = clk_out[1];
        end
        chk("tick1_pattern", 32'(tp), 32'(6'b100100));
        chk("clk1_pattern", 32'(cp), 32'(6'b011100));

        // Channel 2 D=1 then D=0.
        en = 4'b0111;
        wr(2, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            tp[k] = tick[2]; cp[k] = clk_out[2];
        end
        chk("tick2_d1", 32'(tp[3:0]), 32'(4'b1111));
        chk("clk2_d1", 32'(cp[3:0]), 32'(4'b0101));
        wr(2, 0);
        chk("tick2_d0_write", 32'(tick[2]), 0);
        held = clk_out[2]; bad_clk = 0; any_tick = 0;
        repeat (5) begin
            @(negedge clock);
            if (clk_out[2] !== held) bad_clk++;
            if (tick[2]) any_tick++;
        end
        chk("clk2_frozen", 32'(bad_clk), 0);
        chk("tick2_halted", 32'(any_tick), 0);

        // Channel 0 D=5 with a 7-cycle pause at cnt=2.
        wr(0, 5);
        repeat (2) @(negedge clock);
        held = clk_out[0]; en[0] = 1'b0; bad_clk = 0; any_tick = 0;
        repeat (7) begin
            @(negedge clock);
            if (clk_out[0] !== held) bad_clk++;
            if (tick[0]) any_tick++;
        end
        chk("clk0_pause_hold", 32'(bad_clk), 0);
        chk("tick0_pause", 32'(any_tick), 0);
        en[0] = 1'b1; first = 0;
        for (int e = 1; e <= 20 && first == 0; e++) begin
            @(negedge clock);
            if (tick[0]) first = e;
        end
        chk("tick0_resume_edges", 32'(first), 3);

        // Sync with channels 0 and 3 out of phase.
        en = 4'b1111;
        wr(0, 4);
        wr(3, 6);
        repeat (5) @(negedge clock);
        sync = 1'b1;
        @(negedge clock);
        sync = 1'b0;
        chk("clk0_sync", 32'(clk_out[0]), 0);
        chk("clk3_sync", 32'(clk_out[3]), 0);
        e0 = 0; e3 = 0;
        for (int e = 1; e <= 20 && (e0 == 0 || e3 == 0); e++) begin
            @(negedge clock);
            if (tick[0] && e0 == 0) e0 = e;
            if (tick[3] && e3 == 0) e3 = e;
        end
        chk("tick0_after_sync", 32'(e0), 4);
        chk("tick3_after_sync", 32'(e3), 6);

        // Out-of-range write and readback.
        wr(5, 9);
        bus.rd_ch = 3'd5; @(negedge clock); @(negedge clock);
        chk("rd_out_of_range", 32'(bus.rd_div), 0);
        bus.rd_ch = 3'd0; @(negedge clock);
        chk("rd_ch0", 32'(bus.rd_div), 4);
        bus.rd_ch = 3'd1; @(negedge clock);
        chk("rd_ch1", 32'(bus.rd_div), 3);
        bus.rd_ch = 3'd3; @(negedge clock);
        chk("rd_ch3", 32'(bus.rd_div), 6);

        // Mid-count reset with a concurrent write.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus.wr_en = 1'b1; bus.wr_ch = 3'd1; bus.wr_div = 16'd9;
        @(negedge clock);
        chk("midreset_tick", 32'(tick), 0);
        chk("midreset_clk", 32'(clk_out), 0);
        chk("midreset_rd", 32'(bus.rd_div), 0);
        reset = 1'b1; bus.wr_en = 1'b0; bus.rd_ch = 3'd1;
        @(negedge clock);
        chk("rd_ch1_after_reset", 32'(bus.rd_div), 25000);
        repeat (4) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
